// File: rtl/ram_if_pkg.sv
// ---------------------------------------------------------------------------
// ram_if_pkg: shared widths, word layouts and arbiter state encoding for the SKI RAM port.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ram_if_pkg;

  localparam int PTR_W  = 30;
  localparam int DATA_W = 64;

  // Request word {valid, write, ptr, data}; status word {valid, err, data}
  localparam int REQ_W         = 2 + PTR_W + DATA_W;
  localparam int RSP_W         = 2 + DATA_W;
  localparam int REQ_VALID_BIT = REQ_W - 1;
  localparam int REQ_WRITE_BIT = REQ_W - 2;
  localparam int REQ_PTR_MSB   = DATA_W + PTR_W - 1;
  localparam int REQ_PTR_LSB   = DATA_W;
  localparam int REQ_DATA_MSB  = DATA_W - 1;
  localparam int REQ_DATA_LSB  = 0;
  localparam int RSP_VALID_BIT = RSP_W - 1;
  localparam int RSP_ERR_BIT   = RSP_W - 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10
  } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2: two-way round-robin grant; a lone requester always wins.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter2 (
  input  logic [1:0] i_valid,
  input  logic       i_last_grant,
  output logic       o_any,
  output logic       o_grant
);

  assign o_any   = |i_valid;
  assign o_grant = (&i_valid) ? ~i_last_grant : i_valid[1];

endmodule

`default_nettype wire

// File: rtl/ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter: shares the single RAM port between CPU (port 0) and loader (port 1).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ram_port_arbiter #(
  parameter int PTR_W          = ram_if_pkg::PTR_W,
  parameter int DATA_W         = ram_if_pkg::DATA_W,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      system1000,
  input  logic                      system1000_rst,
  input  logic                      req0_valid,
  input  logic                      req0_write,
  input  logic [PTR_W-1:0]          req0_ptr,
  input  logic [DATA_W-1:0]         req0_data,
  output logic                      req0_ready,
  output logic                      rsp0_valid,
  output logic                      rsp0_err,
  output logic [DATA_W-1:0]         rsp0_data,
  input  logic                      req1_valid,
  input  logic                      req1_write,
  input  logic [PTR_W-1:0]          req1_ptr,
  input  logic [DATA_W-1:0]         req1_data,
  output logic                      req1_ready,
  output logic                      rsp1_valid,
  output logic                      rsp1_err,
  output logic [DATA_W-1:0]         rsp1_data,
  output logic [2+PTR_W+DATA_W-1:0] ram_req_o,
  input  logic [2+DATA_W-1:0]       ram_rsp_i,
  output logic                      busy_o,
  output logic                      stray_o,
  output logic [7:0]                timeouts_o
);

  import ram_if_pkg::*;

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t                      r_state;
  state_t                      w_state_next;
  logic                        r_owner;
  logic                        r_last_grant;
  logic                        r_write;
  logic [2+PTR_W+DATA_W-1:0]   r_ram_req;
  logic [15:0]                 r_timer;
  logic                        r_rsp0_valid;
  logic                        r_rsp0_err;
  logic [DATA_W-1:0]           r_rsp0_data;
  logic                        r_rsp1_valid;
  logic                        r_rsp1_err;
  logic [DATA_W-1:0]           r_rsp1_data;
  logic                        r_stray;
  logic [7:0]                  r_timeouts;

  logic                        w_any;
  logic                        w_grant;
  logic                        w_accept;
  logic                        w_grant_write;
  logic [PTR_W-1:0]            w_grant_ptr;
  logic [DATA_W-1:0]           w_grant_data;
  logic                        w_rsp_valid;
  logic                        w_rsp_err;
  logic [DATA_W-1:0]           w_rsp_data;
  logic                        w_timeout;
  logic                        w_done;
  logic                        w_out_err;
  logic [DATA_W-1:0]           w_out_data;

  rr_arbiter2 u_rr (
    .i_valid      ({req1_valid, req0_valid}),
    .i_last_grant (r_last_grant),
    .o_any        (w_any),
    .o_grant      (w_grant)
  );

  assign w_accept      = (r_state == ST_IDLE) && w_any;
  assign req0_ready    = w_accept && !w_grant;
  assign req1_ready    = w_accept && w_grant;
  assign w_grant_write = w_grant ? req1_write : req0_write;
  assign w_grant_ptr   = w_grant ? req1_ptr   : req0_ptr;
  assign w_grant_data  = w_grant ? req1_data  : req0_data;

  assign w_rsp_valid = ram_rsp_i[DATA_W+1];
  assign w_rsp_err   = ram_rsp_i[DATA_W];
  assign w_rsp_data  = ram_rsp_i[DATA_W-1:0];

  // A RAM answer in the final wait cycle beats the timeout
  assign w_timeout  = (r_timer == TIMER_LAST);
  assign w_done     = (r_state == ST_WAIT) && (w_rsp_valid || w_timeout);
  assign w_out_err  = w_rsp_valid ? w_rsp_err : 1'b1;
  assign w_out_data = (w_rsp_valid && !r_write) ? w_rsp_data : '0;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_next = ST_ISSUE;
      ST_ISSUE: w_state_next = ST_WAIT;
      ST_WAIT:  if (w_done) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge system1000 or posedge system1000_rst) begin
    if (system1000_rst) begin
      r_state      <= ST_IDLE;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_write      <= 1'b0;
      r_ram_req    <= '0;
      r_timer      <= '0;
      r_rsp0_valid <= 1'b0;
      r_rsp0_err   <= 1'b0;
      r_rsp0_data  <= '0;
      r_rsp1_valid <= 1'b0;
      r_rsp1_err   <= 1'b0;
      r_rsp1_data  <= '0;
      r_stray      <= 1'b0;
      r_timeouts   <= '0;
    end else begin
      r_state      <= w_state_next;
      r_ram_req    <= '0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;

      if (w_accept) begin
        r_owner      <= w_grant;
        r_last_grant <= w_grant;
        r_write      <= w_grant_write;
        r_ram_req    <= {1'b1, w_grant_write, w_grant_ptr, w_grant_data};
      end

      if (r_state == ST_ISSUE) begin
        r_timer <= '0;
      end else if (r_state == ST_WAIT) begin
        r_timer <= r_timer + 16'd1;
      end

      if (w_rsp_valid && (r_state != ST_WAIT)) begin
        r_stray <= 1'b1;
      end

      if (w_done) begin
        if (r_owner) begin
          r_rsp1_valid <= 1'b1;
          r_rsp1_err   <= w_out_err;
          r_rsp1_data  <= w_out_data;
        end else begin
          r_rsp0_valid <= 1'b1;
          r_rsp0_err   <= w_out_err;
          r_rsp0_data  <= w_out_data;
        end
        if (!w_rsp_valid && (r_timeouts != 8'hFF)) begin
          r_timeouts <= r_timeouts + 8'd1;
        end
      end
    end
  end

  assign ram_req_o  = r_ram_req;
  assign rsp0_valid = r_rsp0_valid;
  assign rsp0_err   = r_rsp0_err;
  assign rsp0_data  = r_rsp0_data;
  assign rsp1_valid = r_rsp1_valid;
  assign rsp1_err   = r_rsp1_err;
  assign rsp1_data  = r_rsp1_data;
  assign busy_o     = (r_state != ST_IDLE);
  assign stray_o    = r_stray;
  assign timeouts_o = r_timeouts;

endmodule

`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_port_arbiter: scoreboard bench with a transaction-level model of the RAM port arbiter.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ram_port_arbiter;

  import ram_if_pkg::*;

  localparam int TO    = 4;
  localparam int NEVER = 32'h7fff_ffff;

  typedef struct { int lat; bit err; logic [DATA_W-1:0] data; } plan_t;
  typedef struct { int cyc; bit err; logic [DATA_W-1:0] data; } ram_ev_t;
  typedef struct { int port; int cyc; bit err; logic [DATA_W-1:0] data; int tmo; } exp_rsp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [1:0]        rv  = '0;
  logic [1:0]        rw  = '0;
  logic [PTR_W-1:0]  rp [2];
  logic [DATA_W-1:0] rd [2];
  logic              rdy0, rdy1, v0, v1, e0, e1;
  logic [DATA_W-1:0] d0, d1;
  logic [REQ_W-1:0]  ram_req;
  logic [RSP_W-1:0]  ram_rsp = '0;
  logic              busy, stray;
  logic [7:0]        tmo;

  ram_port_arbiter #(.PTR_W(PTR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO)) dut (
    .system1000     (clk),
    .system1000_rst (rst),
    .req0_valid     (rv[0]),
    .req0_write     (rw[0]),
    .req0_ptr       (rp[0]),
    .req0_data      (rd[0]),
    .req0_ready     (rdy0),
    .rsp0_valid     (v0),
    .rsp0_err       (e0),
    .rsp0_data      (d0),
    .req1_valid     (rv[1]),
    .req1_write     (rw[1]),
    .req1_ptr       (rp[1]),
    .req1_data      (rd[1]),
    .req1_ready     (rdy1),
    .rsp1_valid     (v1),
    .rsp1_err       (e1),
    .rsp1_data      (d1),
    .ram_req_o      (ram_req),
    .ram_rsp_i      (ram_rsp),
    .busy_o         (busy),
    .stray_o        (stray),
    .timeouts_o     (tmo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Transaction-level model state
  exp_rsp_t          sb[$];
  ram_ev_t           ram_sched[$];
  plan_t             plan_q[$];
  int                grant_log[$];
  int                free_cycle  = 0;
  int                exp_req_cyc = -1;
  logic [REQ_W-1:0]  exp_req_val = '0;
  int                stray_at    = NEVER;
  int                m_tmo       = 0;
  bit                m_last      = 1'b1;
  bit   [1:0]        acc_seen    = '0;
  int                n_accepted  = 0;
  int                n_cmp       = 0;
  int                n_bad       = 0;

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic plan_t mk_plan(input int lat, input bit err, input logic [DATA_W-1:0] data);
    plan_t p;
    p.lat = lat; p.err = err; p.data = data;
    return p;
  endfunction

  // Monitor / scoreboard
  logic     m_g, ex0, ex1;
  bit       m_free;
  int       ap, iss;
  plan_t    pl;
  exp_rsp_t se;

  always @(negedge clk) begin
    if (!rst) begin
      m_free = (cyc >= free_cycle);
      m_g    = (rv == 2'b11) ? ~m_last : rv[1];
      ex0    = m_free && (rv != 2'b00) && !m_g;
      ex1    = m_free && (rv != 2'b00) && m_g;
      chk("req0_ready", 128'(rdy0), 128'(ex0));
      chk("req1_ready", 128'(rdy1), 128'(ex1));
      chk("ram_req_o", 128'(ram_req), (cyc == exp_req_cyc) ? 128'(exp_req_val) : 128'd0);
      chk("busy_o", 128'(busy), 128'(!m_free));
      chk("stray_o", 128'(stray), 128'(cyc >= stray_at));

      if (v0 || v1) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 128'({v1, v0}), 128'd0);
        end else begin
          se = sb.pop_front();
          chk("rsp_cycle", 128'(cyc), 128'(se.cyc));
          chk("rsp_port", 128'({v1, v0}), (se.port == 1) ? 128'd2 : 128'd1);
          chk("rsp_err", 128'(v1 ? e1 : e0), 128'(se.err));
          chk("rsp_data", 128'(v1 ? d1 : d0), 128'(se.data));
          chk("timeouts_o", 128'(tmo), 128'(se.tmo));
        end
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        chk("rsp_missing", 128'd0, 128'd1);
        void'(sb.pop_front());
      end

      if (ex0 || ex1) begin
        ap = ex1 ? 1 : 0;
        acc_seen[ap] = 1'b1;
        n_accepted++;
        grant_log.push_back(ap);
        if (plan_q.size() > 0) begin
          pl = plan_q.pop_front();
        end else begin
          pl.lat  = int'($urandom_range(0, TO + 2));
          pl.err  = ($urandom_range(0, 3) == 0);
          pl.data = {$urandom, $urandom};
        end
        iss         = cyc + 1;
        exp_req_cyc = iss;
        exp_req_val = {1'b1, rw[ap], rp[ap], rd[ap]};
        m_last      = ap[0];
        if (pl.lat > 0) ram_sched.push_back('{iss + pl.lat, pl.err, pl.data});
        se.port = ap;
        if (pl.lat > 0 && pl.lat <= TO) begin
          se.cyc  = iss + pl.lat + 1;
          se.err  = pl.err;
          se.data = rw[ap] ? '0 : pl.data;
        end else begin
          m_tmo   = (m_tmo == 255) ? 255 : m_tmo + 1;
          se.cyc  = iss + TO + 1;
          se.err  = 1'b1;
          se.data = '0;
          if (pl.lat > TO && (iss + pl.lat + 1) < stray_at) stray_at = iss + pl.lat + 1;
        end
        se.tmo = m_tmo;
        sb.push_back(se);
        free_cycle = se.cyc;
      end
    end
  end

  // RAM responder: plays back scheduled status words
  initial begin
    forever begin
      @(posedge clk);
      #1;
      while (ram_sched.size() > 0 && ram_sched[0].cyc < cyc) ram_sched.delete(0);
      if (ram_sched.size() > 0 && ram_sched[0].cyc == cyc) begin
        ram_rsp = {1'b1, ram_sched[0].err, ram_sched[0].data};
        ram_sched.delete(0);
      end else begin
        ram_rsp = '0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int p, input bit w, input logic [PTR_W-1:0] ptr, input logic [DATA_W-1:0] d);
    int k;
    acc_seen[p] = 1'b0;
    rv[p] = 1'b1; rw[p] = w; rp[p] = ptr; rd[p] = d;
    k = 0;
    while (!acc_seen[p] && k < 64) begin
      tick();
      k++;
    end
    if (k >= 64) chk("accept_timeout", 128'd0, 128'd1);
    rv[p] = 1'b0;
    acc_seen[p] = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((sb.size() > 0 || ram_sched.size() > 0 || cyc < free_cycle) && k < 100) begin
      tick();
      k++;
    end
    if (k >= 100) chk("idle_timeout", 128'd0, 128'd1);
    tick();
  endtask

  task automatic apply_reset(input int hold);
    rv  = '0;
    rst = 1'b1;
    #1;
    chk("rst ram_req_o", 128'(ram_req), 128'd0);
    chk("rst busy_o", 128'(busy), 128'd0);
    chk("rst stray_o", 128'(stray), 128'd0);
    chk("rst timeouts_o", 128'(tmo), 128'd0);
    chk("rst rsp_valid", 128'({v1, v0}), 128'd0);
    chk("rst rsp_err", 128'({e1, e0}), 128'd0);
    chk("rst rsp_data", 128'({d1, d0}), 128'd0);
    chk("rst ready", 128'({rdy1, rdy0}), 128'd0);
    sb.delete(); ram_sched.delete(); plan_q.delete();
    exp_req_cyc = -1; m_last = 1'b1; m_tmo = 0; stray_at = NEVER; acc_seen = '0;
    repeat (hold) tick();
    rst = 1'b0;
    free_cycle = cyc;
  endtask

  initial begin
    int k, start;
    rp[0] = '0; rp[1] = '0; rd[0] = '0; rd[1] = '0;
    #2;
    apply_reset(3);

    // Single read from the CPU port
    plan_q.push_back(mk_plan(2, 1'b0, 64'hDEAD_BEEF));
    send(0, 1'b0, 30'h5, {$urandom, $urandom});
    wait_idle();

    // Contention right after reset: port 0 must win first, then alternate
    apply_reset(2);
    repeat (6) plan_q.push_back(mk_plan(1, 1'b0, {$urandom, $urandom}));
    grant_log.delete();
    start = n_accepted;
    for (int p = 0; p < 2; p++) begin
      rv[p] = 1'b1; rw[p] = 1'($urandom); rp[p] = 30'($urandom); rd[p] = {$urandom, $urandom};
    end
    k = 0;
    while (n_accepted < start + 6 && k < 100) begin
      tick();
      k++;
      for (int p = 0; p < 2; p++) begin
        if (acc_seen[p]) begin
          acc_seen[p] = 1'b0;
          rw[p] = 1'($urandom); rp[p] = 30'($urandom); rd[p] = {$urandom, $urandom};
        end
      end
    end
    rv = '0;
    if (k >= 100) chk("contention_timeout", 128'd0, 128'd1);
    for (int i = 0; i < 6 && i < grant_log.size(); i++) chk("contention_grant", 128'(grant_log[i]), 128'(i % 2));
    wait_idle();

    // Write ack on the loader port
    plan_q.push_back(mk_plan(1, 1'b0, 64'h1234));
    send(1, 1'b1, 30'h3FFF_FFFF, {64{1'b1}});
    wait_idle();

    // Silent RAM, then a late answer three cycles after the timeout strobe
    plan_q.push_back(mk_plan(TO + 4, 1'b0, {$urandom, $urandom}));
    send(0, 1'b0, 30'($urandom), '0);
    wait_idle();
    chk("stray_after_timeout", 128'(stray), 128'd1);
    chk("timeouts_after_timeout", 128'(tmo), 128'(m_tmo));

    // Answer landing on the same cycle as the timeout
    plan_q.push_back(mk_plan(TO, 1'b0, {$urandom, $urandom}));
    send(1, 1'b0, 30'($urandom), '0);
    wait_idle();
    plan_q.push_back(mk_plan(TO, 1'b1, {$urandom, $urandom}));
    send(0, 1'b0, 30'($urandom), '0);
    wait_idle();

    // Reset in the middle of WAIT, then an orphaned RAM answer
    plan_q.push_back(mk_plan(TO, 1'b0, {$urandom, $urandom}));
    send(0, 1'b0, 30'($urandom), {$urandom, $urandom});
    tick();
    tick();
    apply_reset(2);
    ram_sched.push_back('{cyc + 2, 1'b0, 64'hABCD});
    stray_at = cyc + 3;
    repeat (5) tick();
    plan_q.push_back(mk_plan(1, 1'b0, 64'h55AA));
    send(0, 1'b0, 30'h77, '0);
    wait_idle();
    chk("stray_after_reset", 128'(stray), 128'd1);

    // Randomized traffic on both ports
    for (int i = 0; i < 600; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (acc_seen[p]) begin
          acc_seen[p] = 1'b0;
          rv[p] = 1'b0;
        end
        if (!rv[p] && $urandom_range(0, 3) == 0) begin
          rv[p] = 1'b1; rw[p] = 1'($urandom); rp[p] = 30'($urandom); rd[p] = {$urandom, $urandom};
        end
      end
      tick();
    end
    rv = '0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single SKI-machine RAM port between two requesters: port 0 is the CPU, port 1 is the loader/collector.
- Requests use the RAM request packing {valid, write, ptr[29:0], data[63:0]} (96 bits). RAM status uses {valid, err, data[63:0]} (66 bits).
- Allows one outstanding RAM transaction. Round-robin grant. Each response is routed back to the port that issued it.
- A timeout guard returns an error if the RAM never answers.

Parameters:
- PTR_W, 30, pointer width.
- DATA_W, 64, binarized word width.
- TIMEOUT_CYCLES, 255, number of WAIT cycles before the block gives up. Legal range 1..65535.

Ports:
- system1000  in  1  clock
- system1000_rst  in  1  reset, asynchronous, active-high
- req0_valid  in  1  port-0 request valid
- req0_write  in  1  1=write, 0=read
- req0_ptr  in  PTR_W  address
- req0_data  in  DATA_W  write data
- req0_ready  out  1  port-0 request accepted this cycle when valid&ready
- rsp0_valid  out  1  port-0 response strobe, one cycle
- rsp0_err  out  1  timeout error
- rsp0_data  out  DATA_W  read data (0 on write ack or error)
- req1_*, rsp1_*  same set as port 0
- ram_req_o  out  2+PTR_W+DATA_W  {valid, write, ptr, data} to RAM
- ram_rsp_i  in  2+DATA_W  {valid, err, data} from RAM
- busy_o  out  1  state != IDLE
- stray_o  out  1  sticky: RAM response arrived outside WAIT
- timeouts_o  out  8  saturating timeout count

Behaviour:
- Reset (async, active-high):
  - state=IDLE, last_grant=1 (so port 0 wins first).
  - All outputs 0, including ram_req_o, stray_o and timeouts_o.
- States: IDLE, ISSUE, WAIT.
- IDLE, grant selection:
  - Only one requester valid: that port is granted.
  - Both valid: the port != last_grant is granted.
  - reqX_ready = (state==IDLE) & granted port == X. This is combinational from state, valids and last_grant. The non-granted ready is 0.
- IDLE, on valid&ready:
  - Latch write/ptr/data and owner.
  - last_grant <= owner.
  - Go to ISSUE.
- ISSUE:
  - ram_req_o = {1, write, ptr, data} for exactly one cycle, registered.
  - Go to WAIT and clear the timer.
  - ram_req_o returns to all-zero in every state other than ISSUE.
- WAIT:
  - timer += 1 each cycle.
  - On ram_rsp_i.valid: next cycle rsp<owner>_valid=1, err=ram_rsp_i.err, data=ram_rsp_i.data (data forced to 0 for a write). State becomes IDLE.
  - When timer reaches TIMEOUT_CYCLES with no response: next cycle rsp<owner>_valid=1, err=1, data=0. timeouts_o += 1, saturating at 255. State becomes IDLE.
  - If a response and the timeout occur in the same cycle, the response wins and no timeout is counted.
- Response outputs:
  - rspX_valid is a single-cycle strobe.
  - rspX_err and rspX_data are held until the next strobe on that port.
- Back-to-back operation:
  - The cycle rsp is strobed is already IDLE, so a new request may be accepted in that same cycle.
  - Minimum turnaround is 3 cycles per transaction when the RAM answers 1 cycle after ISSUE.
- Stray responses:
  - ram_rsp_i.valid in IDLE or ISSUE is dropped and sets stray_o. stray_o clears only on reset.
  - A late response after a timeout is therefore stray.
  - A RAM response that arrives after a mid-operation reset is also stray.
- Reset mid-transaction:
  - The outstanding request is abandoned with no response to the owner.
  - The requester must re-issue it.
- Requester inputs are not required to stay stable after acceptance, because they are latched on acceptance.

Decomposition:
- Shared package ram_if_pkg, which both the CPU and RAM sides import:
  - PTR_W and DATA_W.
  - Field offsets of the request and status words: valid bit, write bit, ptr range, data range.
  - State encoding: IDLE=2'b00, ISSUE=2'b01, WAIT=2'b10.
- One natural sub-module, rr_arbiter2: the 2-way round-robin grant logic, taking (valids, last_grant) and producing grant.
- Everything else stays in the top.

Test Plan:
- Single read:
  - Stimulus: reset, then req0 read ptr=0x5; RAM answers {1,0,0xDEAD_BEEF} 2 cycles after ISSUE.
  - Required: ram_req_o valid exactly 1 cycle with ptr=5; rsp0_valid for 1 cycle with data=0xDEADBEEF, err=0; rsp1_valid never asserted.
- Contention fairness:
  - Stimulus: req0 and req1 held valid continuously for 6 transactions.
  - Required: grants alternate 0,1,0,1,0,1; each response appears only on its owner's port.
- Write ack:
  - Stimulus: req1 write ptr=0x3FFF_FFFF, data=all-ones; RAM returns valid with data=0x1234.
  - Required: ram_req_o = {1,1,0x3FFFFFFF,all-ones}; rsp1_data=0, err=0.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=4; RAM stays silent.
  - Required: rsp0_valid with err=1 exactly 5 cycles after ISSUE; timeouts_o=1.
  - Then a RAM response 3 cycles later: stray_o=1 and no rsp strobe.
- Reset mid-WAIT:
  - Stimulus: assert system1000_rst during WAIT, then RAM responds after reset is released.
  - Required: all outputs 0 immediately (async); no rsp strobe; stray_o=1; next req0 is accepted normally.
- Simultaneous events:
  - Stimulus: RAM response arrives on the same cycle the timer hits TIMEOUT_CYCLES.
  - Required: normal response with err = RAM err; timeouts_o unchanged.
